// File: rtl/conv_tile_loader.sv
// conv_tile_loader: captures 9 weights then 16 activations from a byte stream and drives the 3x3/4x4 array run.
// Latency: active_sa3/busy rise the cycle after the last beat; tile_done pulses the cycle after done_sa3.
// Backpressure: s_ready is combinational, low for the whole run. Optional TILE_LOADER_WEIGHT_REUSE_EN adds wt_keep.
module conv_tile_loader #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] a11, a12, a13, a14,
    output logic [DATA_W-1:0] a21, a22, a23, a24,
    output logic [DATA_W-1:0] a31, a32, a33, a34,
    output logic [DATA_W-1:0] a41, a42, a43, a44,
    output logic [DATA_W-1:0] b11, b12, b13,
    output logic [DATA_W-1:0] b21, b22, b23,
    output logic [DATA_W-1:0] b31, b32, b33,
    output logic              active_sa3,
    input  logic              done_sa3,
`ifdef TILE_LOADER_WEIGHT_REUSE_EN
    input  logic              wt_keep,
`endif
    output logic              tile_done,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [1:0] {LOAD_W, LOAD_A, RUN} state_t;

    localparam logic [4:0] CNT_W_LAST  = 5'd8;
    localparam logic [4:0] CNT_A_LAST  = 5'd15;
    localparam logic [4:0] CNT_TO_LAST = 5'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] b_q [9];
    logic [DATA_W-1:0] b_d [9];
    logic [DATA_W-1:0] a_q [16];
    logic [DATA_W-1:0] a_d [16];
    logic              active_q, active_d;
    logic              busy_q, busy_d;
    logic              tile_done_q, tile_done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              keep_w;

    assign s_ready = (state_q == LOAD_W) || (state_q == LOAD_A);
    assign accept  = s_valid && s_ready;

`ifdef TILE_LOADER_WEIGHT_REUSE_EN
    assign keep_w = wt_keep;
`else
    assign keep_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        a_d         = a_q;
        active_d    = active_q;
        busy_d      = busy_q;
        tile_done_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            LOAD_W: begin
                if (accept) begin
                    for (int i = 0; i < 9; i++)
                        if (cnt_q == 5'(i)) b_d[i] = s_data;
                    if (cnt_q == CNT_W_LAST) begin
                        state_d = LOAD_A;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            LOAD_A: begin
                if (accept) begin
                    for (int i = 0; i < 16; i++)
                        if (cnt_q == 5'(i)) a_d[i] = s_data;
                    if (cnt_q == CNT_A_LAST) begin
                        state_d  = RUN;
                        cnt_d    = 5'd0;
                        active_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (done_sa3) begin
                    state_d     = keep_w ? LOAD_A : LOAD_W;
                    cnt_d       = 5'd0;
                    active_d    = 1'b0;
                    busy_d      = 1'b0;
                    tile_done_d = 1'b1;
                end else if (cnt_q == CNT_TO_LAST) begin
                    state_d  = LOAD_W;
                    cnt_d    = 5'd0;
                    active_d = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                end
            end
            default: begin
                state_d = LOAD_W;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD_W;
            cnt_q       <= 5'd0;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 9; i++)  b_q[i] <= '0;
            for (int i = 0; i < 16; i++) a_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            tile_done_q <= tile_done_d;
            err_q       <= err_d;
            b_q         <= b_d;
            a_q         <= a_d;
        end
    end

    assign active_sa3  = active_q;
    assign busy        = busy_q;
    assign tile_done   = tile_done_q;
    assign err_timeout = err_q;

    assign b11 = b_q[0];  assign b12 = b_q[1];  assign b13 = b_q[2];
    assign b21 = b_q[3];  assign b22 = b_q[4];  assign b23 = b_q[5];
    assign b31 = b_q[6];  assign b32 = b_q[7];  assign b33 = b_q[8];

    assign a11 = a_q[0];  assign a12 = a_q[1];  assign a13 = a_q[2];  assign a14 = a_q[3];
    assign a21 = a_q[4];  assign a22 = a_q[5];  assign a23 = a_q[6];  assign a24 = a_q[7];
    assign a31 = a_q[8];  assign a32 = a_q[9];  assign a33 = a_q[10]; assign a34 = a_q[11];
    assign a41 = a_q[12]; assign a42 = a_q[13]; assign a43 = a_q[14]; assign a44 = a_q[15];

endmodule

// File: tb/tb_conv_tile_loader.sv
// Bench for conv_tile_loader: random tiles through a byte-stream driver, an array model and a scoreboard monitor.
// Build with +define+TILE_LOADER_WEIGHT_REUSE_EN to also exercise weight reuse.
module tb_conv_tile_loader;

    localparam int DW = 8;
    localparam int TO = 32;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [DW-1:0] a31, a32, a33, a34, a41, a42, a43, a44;
    logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic          active_sa3;
    logic          done_sa3;
    logic          tile_done;
    logic          busy;
    logic          err_timeout;
`ifdef TILE_LOADER_WEIGHT_REUSE_EN
    logic          wt_keep;
`endif

    conv_tile_loader #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .a11(a11), .a12(a12), .a13(a13), .a14(a14),
        .a21(a21), .a22(a22), .a23(a23), .a24(a24),
        .a31(a31), .a32(a32), .a33(a33), .a34(a34),
        .a41(a41), .a42(a42), .a43(a43), .a44(a44),
        .b11(b11), .b12(b12), .b13(b13),
        .b21(b21), .b22(b22), .b23(b23),
        .b31(b31), .b32(b32), .b33(b33),
        .active_sa3(active_sa3), .done_sa3(done_sa3),
`ifdef TILE_LOADER_WEIGHT_REUSE_EN
        .wt_keep(wt_keep),
`endif
        .tile_done(tile_done), .busy(busy), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [71:0]  dut_b;
    logic [127:0] dut_a;
    assign dut_b = {b11, b12, b13, b21, b22, b23, b31, b32, b33};
    assign dut_a = {a11, a12, a13, a14, a21, a22, a23, a24,
                    a31, a32, a33, a34, a41, a42, a43, a44};

    typedef struct {
        logic [71:0]  b;
        logic [127:0] a;
        logic         done;
        int           len;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mb [9];
    logic [DW-1:0] ma [16];
    logic [DW-1:0] tdat [25];
    int            n_chk = 0;
    int            n_err = 0;
    int            done_at = 17;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] pack_b();
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[71-8*i -: 8] = mb[i];
        return v;
    endfunction

    function automatic logic [127:0] pack_a();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = ma[i];
        return v;
    endfunction

    // Array model: done in the done_at-th active cycle; random noise on done_sa3 while idle.
    int act_cnt = 0;
    initial begin
        done_sa3 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (active_sa3) begin
                act_cnt++;
                done_sa3 = (act_cnt == done_at);
            end else begin
                act_cnt  = 0;
                done_sa3 = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Scoreboard monitor.
    exp_t cur;
    bit   act_prev = 0;
    bit   have = 0;
    bit   exp_err = 0;
    bit   fall;
    bit   exp_td;
    int   run_cnt = 0;
    int   cyc = 0;
    int   last_acc = -10;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                act_prev = 0;
                have     = 0;
                run_cnt  = 0;
                exp_err  = 0;
                continue;
            end
            fall   = act_prev && !active_sa3;
            exp_td = 0;
            if (active_sa3 && !act_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_run", 1, 0);
                    have = 0;
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1;
                    chk("run_start_latency", cyc - last_acc, 1);
                    chk("b_regs_at_start", dut_b, cur.b);
                    chk("a_regs_at_start", dut_a, cur.a);
                end
                run_cnt = 0;
            end
            if (active_sa3) begin
                run_cnt++;
                chk("s_ready_in_run", s_ready, 0);
            end
            if (fall && have) begin
                exp_td = cur.done;
                if (!cur.done) exp_err = 1;
                chk("run_length", run_cnt, cur.len);
                chk("b_regs_at_end", dut_b, cur.b);
                chk("a_regs_at_end", dut_a, cur.a);
                chk("s_ready_after_run", s_ready, 1);
                have = 0;
            end
            chk("tile_done", tile_done, exp_td);
            chk("busy", busy, active_sa3);
            chk("err_timeout", err_timeout, exp_err);
            if (s_valid && s_ready) last_acc = cyc;
            act_prev = active_sa3;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit gap);
        int w;
        if (gap) begin
            s_valid = 1'b0;
            s_data  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        w = 0;
        @(negedge clk);
        while (!s_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!s_ready) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic run_tile(input int n, input bit gap, input bit ff, input int d_at, input bit keep);
        exp_t e;
        bit   seen;
        int   w;
        done_at = d_at;
`ifdef TILE_LOADER_WEIGHT_REUSE_EN
        wt_keep = keep;
`else
        if (keep) chk("keep_unsupported", 1, 0);
`endif
        if (n == 25) for (int i = 0; i < 9; i++) mb[i] = tdat[i];
        for (int j = 0; j < 16; j++) ma[j] = tdat[n-16+j];
        e.b    = pack_b();
        e.a    = pack_a();
        e.done = (d_at <= TO);
        e.len  = (d_at <= TO) ? d_at : TO;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) send_beat(tdat[i], gap);
        seen = 0;
        w    = 0;
        while (w < 200 && !(seen && !active_sa3)) begin
            s_valid = ff && active_sa3;
            s_data  = ff ? 8'hFF : 8'h00;
            if (active_sa3) seen = 1;
            @(posedge clk);
            #1;
            w++;
        end
        s_valid = 1'b0;
        if (w >= 200) chk("run_complete_timeout", 0, 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_active"}, active_sa3, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tile_done"}, tile_done, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_b_regs"}, dut_b, 0);
        chk({tag, "_a_regs"}, dut_a, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
`ifdef TILE_LOADER_WEIGHT_REUSE_EN
        wt_keep = 1'b0;
`endif
        for (int i = 0; i < 9; i++)  mb[i] = '0;
        for (int i = 0; i < 16; i++) ma[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("in_reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("after_reset");

        // Back-to-back 1..25, nominal 17-cycle run.
        for (int i = 0; i < 25; i++) tdat[i] = DW'(i + 1);
        run_tile(25, 0, 0, 17, 0);
        chk("b11_val", b11, 1);
        chk("b33_val", b33, 9);
        chk("a11_val", a11, 10);
        chk("a44_val", a44, 25);

        // Gapped stream, 0xFF offered throughout the run.
        run_tile(25, 1, 1, 17, 0);

        // Array never completes: watchdog, then a normal tile with the flag still sticky.
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(25, 0, 0, 1000, 0);
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(25, 1, 0, 17, 0);

        // Reset mid-load discards the partial tile.
        for (int i = 0; i < 12; i++) send_beat(DW'($urandom), 0);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("mid_load_reset");
        for (int i = 0; i < 9; i++)  mb[i] = '0;
        for (int i = 0; i < 16; i++) ma[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) tdat[i] = DW'(101 + i);
        run_tile(25, 0, 0, 17, 0);
        chk("b11_after_reset", b11, 101);
        chk("a44_after_reset", a44, 125);

        // Boundaries: done in first run cycle, done coinciding with watchdog, then random.
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(25, 0, 0, 1, 0);
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(25, 1, 1, TO, 0);
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
            run_tile(25, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, TO + 2), 0);
        end

`ifdef TILE_LOADER_WEIGHT_REUSE_EN
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(25, 0, 0, 17, 1);
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(16, 1, 0, 17, 0);
        for (int i = 0; i < 25; i++) tdat[i] = DW'($urandom);
        run_tile(25, 0, 0, 17, 0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
